// File: rtl/tnn_neuron_serial.sv
// ---------------------------------------------------------------------------
// tnn_neuron_serial
//
// Serial ternary-weight neuron. Consumes one unsigned IN_W-bit feature per
// valid/ready beat. Each feature is multiplied by a compile-time ternary
// weight (+1 / 0 / -1) and added into a signed accumulator. After N_IN
// features the block produces a class bit (acc > THRESH) and the signed
// margin (acc - THRESH), which are held until the consumer takes them.
//
// Ports:
//   clk         rising-edge clock for all state
//   rst_n       synchronous active-low reset
//   flush       synchronous abort of a partially collected vector
//   in_valid    feature beat valid
//   in_ready    block can accept a feature (registered)
//   in_data     unsigned feature value, IN_W bits
//   out_valid   result valid (registered)
//   out_ready   consumer accepts the result
//   out_class   1 when the weighted sum is strictly greater than THRESH
//   out_margin  signed (acc - THRESH), ACC_W bits, two's complement
//   in_idx      index of the next feature expected (status only)
//
// Weight codes (2 bits per feature, feature i at [2i+1:2i]):
//   2'b01 = +1, 2'b11 = -1, 2'b00 / 2'b10 = 0.
// ---------------------------------------------------------------------------
module tnn_neuron_serial #(
    parameter int                IN_W    = 2,
    parameter int                N_IN    = 5,
    parameter logic [2*N_IN-1:0] WEIGHTS = 10'h377,
    parameter int                THRESH  = 0,
    parameter int                ACC_W   = IN_W + $clog2(N_IN + 1) + 1,
    localparam int               IDX_W   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_class,
    output logic [ACC_W-1:0] out_margin,
    output logic [IDX_W-1:0] in_idx
);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_DONE    = 1'b1;

    localparam logic [2*N_IN-1:0]       W_VEC    = WEIGHTS;
    localparam logic signed [ACC_W-1:0] THRESH_V = ACC_W'(THRESH);
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N_IN - 1);
    localparam logic [IDX_W-1:0]        IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]        IDX_ZERO = {IDX_W{1'b0}};
    localparam logic signed [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

    // Signed range of an ACC_W-bit value; THRESH has to fit inside it.
    localparam longint ACC_MAX = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
    localparam longint ACC_MIN = -ACC_MAX - 64'sd1;

    // Elaboration-time parameter sanity check.
    generate
        if ((N_IN < 1) || (longint'(THRESH) > ACC_MAX) || (longint'(THRESH) < ACC_MIN)) begin : g_param_check
            $error("tnn_neuron_serial: N_IN must be >= 1 and THRESH must fit in ACC_W signed range");
        end
    endgenerate

    logic [0:0]              state_r;
    logic signed [ACC_W-1:0] acc_r;
    logic [IDX_W-1:0]        idx_r;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic                    out_class_r;
    logic signed [ACC_W-1:0] out_margin_r;

    logic [1:0]              w_code_s;
    logic [ACC_W-1:0]        feat_ext_s;
    logic signed [ACC_W-1:0] term_s;
    logic signed [ACC_W-1:0] acc_next_s;
    logic signed [ACC_W-1:0] margin_next_s;
    logic                    class_next_s;
    logic                    accept_s;
    logic                    last_s;

    // Weighted term for the current feature and the resulting accumulator.
    always_comb begin
        w_code_s      = W_VEC[2*int'(idx_r) +: 2];
        feat_ext_s    = {{(ACC_W-IN_W){1'b0}}, in_data};
        term_s        = ACC_ZERO;
        case (w_code_s)
            2'b01:   term_s = feat_ext_s;
            2'b11:   term_s = -feat_ext_s;
            default: term_s = ACC_ZERO;
        endcase
        acc_next_s    = acc_r + term_s;
        margin_next_s = acc_next_s - THRESH_V;
        class_next_s  = (acc_next_s > THRESH_V);
        // A flush in the same cycle drops the beat.
        accept_s      = (state_r == ST_COLLECT) && in_ready_r && in_valid && !flush;
        last_s        = (idx_r == LAST_IDX);
    end

    // Collect/done sequencer, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_COLLECT;
            acc_r        <= ACC_ZERO;
            idx_r        <= IDX_ZERO;
            in_ready_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            out_class_r  <= 1'b0;
            out_margin_r <= ACC_ZERO;
        end else begin
            case (state_r)
                ST_COLLECT: begin
                    in_ready_r <= 1'b1;
                    if (flush) begin
                        acc_r <= ACC_ZERO;
                        idx_r <= IDX_ZERO;
                    end else if (accept_s) begin
                        acc_r <= acc_next_s;
                        if (last_s) begin
                            out_class_r  <= class_next_s;
                            out_margin_r <= margin_next_s;
                            out_valid_r  <= 1'b1;
                            idx_r        <= IDX_ZERO;
                            in_ready_r   <= 1'b0;
                            state_r      <= ST_DONE;
                        end else begin
                            idx_r <= idx_r + IDX_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    // flush is ignored here so a pending result survives.
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        acc_r       <= ACC_ZERO;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_COLLECT;
                    end
                end
                default: begin
                    state_r     <= ST_COLLECT;
                    acc_r       <= ACC_ZERO;
                    idx_r       <= IDX_ZERO;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_class  = out_class_r;
    assign out_margin = out_margin_r;
    assign in_idx     = idx_r;

endmodule
